// File: rtl/axi_lite_multich_soc.sv
// AXI-Lite register front end for NUM_CH fixed-latency "operand + 1" compute channels,
// with sticky W1C DONE/OVERRUN flags, per-channel interrupt enables and a registered IRQ.
module axi_lite_multich_soc #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned LATENCY    = 4
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic                  WVALID,
   output logic                  WREADY,
   input  logic [DATA_WIDTH-1:0] WDATA,
   output logic                  BVALID,
   input  logic                  BREADY,
   output logic [1:0]            BRESP,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic [1:0]            RRESP,
   output logic                  IRQ
);
   localparam logic [1:0]            RespOkay   = 2'b00;
   localparam logic [1:0]            RespSlverr = 2'b10;
   localparam logic [7:0]            NumCh8     = 8'(NUM_CH);
   localparam logic [7:0]            Lat8       = 8'(LATENCY);
   localparam logic [4:0]            Lat5       = 5'(LATENCY);
   localparam logic [31:0]           IdValue    = {16'h5343, Lat8, NumCh8};
   localparam logic [DATA_WIDTH-1:0] DataOne    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {StIdle, StRun} ch_state_e;

   ch_state_e             state_q    [NUM_CH];
   logic [4:0]            cnt_q      [NUM_CH];
   logic [DATA_WIDTH-1:0] data_in_q  [NUM_CH];
   logic [DATA_WIDTH-1:0] operand_q  [NUM_CH];
   logic [DATA_WIDTH-1:0] data_out_q [NUM_CH];
   logic [NUM_CH-1:0]     irq_en_q, done_q, ovr_q;

   logic                  bvalid_q, rvalid_q, irq_q;
   logic [1:0]            bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic [7:0]            wr_win, rd_win;
   logic [1:0]            wr_reg, rd_reg;
   logic                  wr_hs, rd_hs, wr_err, rd_err;
   logic [NUM_CH-1:0]     wr_sel, busy, finish, irq_vec;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  unused_bits;

   assign wr_win      = AWADDR[11:4];
   assign wr_reg      = AWADDR[3:2];
   assign rd_win      = ARADDR[11:4];
   assign rd_reg      = ARADDR[3:2];
   assign wr_hs       = AWVALID & WVALID & ~bvalid_q & ~ARESET;
   assign rd_hs       = ARVALID & ~rvalid_q & ~ARESET;
   // Only CTRL, DATA_IN and STATUS of a present channel are writable.
   assign wr_err      = (wr_win >= NumCh8) || (wr_reg == 2'd3);
   assign irq_vec     = done_q & irq_en_q;
   assign unused_bits = ^{AWADDR, ARADDR, WDATA};

   assign AWREADY = wr_hs;
   assign WREADY  = wr_hs;
   assign ARREADY = rd_hs;
   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   assign RVALID  = rvalid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;
   assign IRQ     = irq_q;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         busy[c]   = (state_q[c] == StRun);
         finish[c] = busy[c] && (cnt_q[c] == 5'd1);
         wr_sel[c] = wr_hs && !wr_err && (wr_win == 8'(c));
      end
   end

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_win == 8'(c)) begin
            rd_err = 1'b0;
            case (rd_reg)
               2'd0:    rd_data[1]   = irq_en_q[c];
               2'd1:    rd_data      = data_in_q[c];
               2'd2:    rd_data[2:0] = {ovr_q[c], done_q[c], busy[c]};
               default: rd_data      = data_out_q[c];
            endcase
         end
      end
      if (ARADDR[11:2] == 10'h040) begin
         rd_err              = 1'b0;
         rd_data[NUM_CH-1:0] = irq_vec;
      end else if (ARADDR[11:2] == 10'h041) begin
         rd_err        = 1'b0;
         rd_data[31:0] = IdValue;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         bvalid_q <= 1'b0;
         bresp_q  <= RespOkay;
         rvalid_q <= 1'b0;
         rresp_q  <= RespOkay;
         rdata_q  <= '0;
         irq_q    <= 1'b0;
         irq_en_q <= '0;
         done_q   <= '0;
         ovr_q    <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c]    <= StIdle;
            cnt_q[c]      <= '0;
            data_in_q[c]  <= '0;
            operand_q[c]  <= '0;
            data_out_q[c] <= '0;
         end
      end else begin
         if (wr_hs) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_err ? RespSlverr : RespOkay;
         end else if (BREADY) begin
            bvalid_q <= 1'b0;
         end

         if (rd_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_err ? RespSlverr : RespOkay;
         end else if (RREADY) begin
            rvalid_q <= 1'b0;
         end

         irq_q <= |irq_vec;

         for (int c = 0; c < NUM_CH; c++) begin
            if (busy[c]) cnt_q[c] <= cnt_q[c] - 5'd1;
            if (finish[c]) begin
               state_q[c]    <= StIdle;
               data_out_q[c] <= operand_q[c] + DataOne;
            end
            if (wr_sel[c]) begin
               case (wr_reg)
                  2'd0: begin
                     irq_en_q[c] <= WDATA[1];
                     if (WDATA[0] && !busy[c]) begin
                        state_q[c]   <= StRun;
                        cnt_q[c]     <= Lat5;
                        operand_q[c] <= data_in_q[c];
                     end
                  end
                  2'd1: data_in_q[c] <= WDATA;
                  2'd2: begin
                     if (WDATA[1]) done_q[c] <= 1'b0;
                     if (WDATA[2]) ovr_q[c]  <= 1'b0;
                  end
                  default: ;
               endcase
            end
            // Sets come after the W1C clears so a same-edge set wins.
            if (finish[c]) done_q[c] <= 1'b1;
            if (wr_sel[c] && (wr_reg == 2'd0) && WDATA[0] && busy[c]) ovr_q[c] <= 1'b1;
         end
      end
   end

endmodule
